asymmetric_pack_fifo: RTL and testbench

- Narrow-write, wide-read FIFO: the write side of an asymmetric width conversion.
- Accepts a stream of WIDTH_IN words and packs each RATIO consecutive words into one WIDTH_OUT word.
- Stores packed words in distributed RAM and presents them on a valid/ready output.
- Sits upstream of wide consumers that are fed from narrow producers, e.g. byte streams assembled into 64-bit datapath words.

---
 rtl/asymmetric_pack_fifo_pkg.sv | 14 +
 rtl/asymmetric_pack_fifo_if.sv | 24 ++
 rtl/asymmetric_pack_fifo_packing_distributed_ram.sv | 40 ++++
 rtl/asymmetric_pack_fifo.sv | 94 +++++++++
 tb/tb_asymmetric_pack_fifo.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/asymmetric_pack_fifo_pkg.sv
// Shared helpers for the asymmetric packing FIFO: compile-time log2 used to
// derive lane and address widths from the width/depth parameters.
package asymmetric_pack_fifo_pkg;

  function automatic int log2_ceil(input int value);
    int r;
    r = 0;
    while ((32'sd1 <<< r) < value) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/asymmetric_pack_fifo_if.sv
// Narrow-in / wide-out handshake bundle; slave is the FIFO side, master the producer/consumer side.
interface asymmetric_pack_fifo_if #(
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_OUT = 64,
  parameter int ADDR_W    = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH_IN-1:0]  in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH_OUT-1:0] out_data;
  logic [ADDR_W:0]      count;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/asymmetric_pack_fifo_packing_distributed_ram.sv
// Narrow-write / wide-read distributed RAM: one WIDTH_IN-wide array per lane,
// written lane by lane, read asynchronously as the concatenation of all lanes.
module packing_distributed_ram
  import asymmetric_pack_fifo_pkg::*;
#(
  parameter int  WIDTH_IN   = 8,
  parameter int  WIDTH_OUT  = 64,
  parameter int  DEPTH_OUT  = 32,
  localparam int RATIO      = WIDTH_OUT / WIDTH_IN,
  localparam int LOG2_RATIO = log2_ceil(RATIO),
  localparam int ADDR_W     = log2_ceil(DEPTH_OUT)
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [ADDR_W+LOG2_RATIO-1:0] waddr,
  input  logic [WIDTH_IN-1:0]          in,
  input  logic [ADDR_W-1:0]            raddr,
  output logic [WIDTH_OUT-1:0]         out
);

  logic [LOG2_RATIO-1:0] wlane_s;
  logic [ADDR_W-1:0]     wrow_s;

  assign wlane_s = waddr[LOG2_RATIO-1:0];
  assign wrow_s  = waddr[ADDR_W+LOG2_RATIO-1:LOG2_RATIO];

  for (genvar g = 0; g < RATIO; g++) begin : g_lane
    logic [WIDTH_IN-1:0] mem [DEPTH_OUT];

    // Lane storage: written only when the low address bits select this lane.
    always_ff @(posedge clk) begin
      if (we && (wlane_s == LOG2_RATIO'(g))) begin
        mem[wrow_s] <= in;
      end
    end

    assign out[g*WIDTH_IN +: WIDTH_IN] = mem[raddr];
  end

endmodule

// File: rtl/asymmetric_pack_fifo.sv
// Packs RATIO narrow words (first word in the LSBs) into one wide entry and
// serves completed entries in order; a partially filled entry is never visible.
module asymmetric_pack_fifo
  import asymmetric_pack_fifo_pkg::*;
#(
  parameter int  WIDTH_IN   = 8,
  parameter int  WIDTH_OUT  = 64,
  parameter int  DEPTH_OUT  = 32,
  localparam int RATIO      = WIDTH_OUT / WIDTH_IN,
  localparam int LOG2_RATIO = log2_ceil(RATIO),
  localparam int ADDR_W     = log2_ceil(DEPTH_OUT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  asymmetric_pack_fifo_if.slave bus
);

  localparam logic [LOG2_RATIO-1:0] LANE_LAST  = LOG2_RATIO'(RATIO - 1);
  localparam logic [ADDR_W:0]       COUNT_FULL = (ADDR_W + 1)'(DEPTH_OUT);
  localparam logic [ADDR_W:0]       COUNT_ZERO = {(ADDR_W + 1){1'b0}};

  logic [LOG2_RATIO-1:0] lane_q, lane_d;
  logic [ADDR_W-1:0]     wr_idx_q, wr_idx_d;
  logic [ADDR_W-1:0]     rd_idx_q, rd_idx_d;
  logic [ADDR_W:0]       count_q, count_d;
  logic                  in_fire_s, out_fire_s, complete_s;

  // Handshakes depend on stored count only, so out_ready never reaches in_ready.
  assign bus.in_ready  = (count_q != COUNT_FULL);
  assign bus.out_valid = (count_q != COUNT_ZERO);
  assign bus.count     = count_q;
  assign in_fire_s     = bus.in_valid & bus.in_ready;
  assign out_fire_s    = bus.out_valid & bus.out_ready;

  // Next-state for lane counter, pointers and completed-entry count.
  always_comb begin
    lane_d     = lane_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    count_d    = count_q;
    complete_s = 1'b0;
    if (in_fire_s) begin
      lane_d     = lane_q + LOG2_RATIO'(1'b1);
      complete_s = (lane_q == LANE_LAST);
    end else begin
      lane_d     = lane_q;
      complete_s = 1'b0;
    end
    if (complete_s) begin
      wr_idx_d = wr_idx_q + ADDR_W'(1'b1);
    end else begin
      wr_idx_d = wr_idx_q;
    end
    if (out_fire_s) begin
      rd_idx_d = rd_idx_q + ADDR_W'(1'b1);
    end else begin
      rd_idx_d = rd_idx_q;
    end
    case ({complete_s, out_fire_s})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1'b1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset drops any partial word and empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q   <= {LOG2_RATIO{1'b0}};
      wr_idx_q <= {ADDR_W{1'b0}};
      rd_idx_q <= {ADDR_W{1'b0}};
      count_q  <= COUNT_ZERO;
    end else begin
      lane_q   <= lane_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      count_q  <= count_d;
    end
  end

  packing_distributed_ram #(
    .WIDTH_IN  (WIDTH_IN),
    .WIDTH_OUT (WIDTH_OUT),
    .DEPTH_OUT (DEPTH_OUT)
  ) u_ram (
    .clk   (clk),
    .we    (in_fire_s),
    .waddr ({wr_idx_q, lane_q}),
    .in    (bus.in_data),
    .raddr (rd_idx_q),
    .out   (bus.out_data)
  );

endmodule

// File: tb/tb_asymmetric_pack_fifo.sv
// Directed + randomized bench: default 8->64 x32 FIFO against a queue model,
// plus a 16->32 x4 instance checked with fixed expected words.
module tb_asymmetric_pack_fifo;

  localparam int D1 = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  logic [63:0] exp_q [$];
  logic [7:0]  part_q [$];
  logic        last_acc;

  always #5 clk = ~clk;

  asymmetric_pack_fifo_if #(.WIDTH_IN(8),  .WIDTH_OUT(64), .ADDR_W(5)) a_if ();
  asymmetric_pack_fifo_if #(.WIDTH_IN(16), .WIDTH_OUT(32), .ADDR_W(2)) b_if ();

  asymmetric_pack_fifo #(.WIDTH_IN(8), .WIDTH_OUT(64), .DEPTH_OUT(32)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if)
  );

  asymmetric_pack_fifo #(.WIDTH_IN(16), .WIDTH_OUT(32), .DEPTH_OUT(4)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_a();
    check("a_out_valid", 64'(a_if.out_valid), 64'(exp_q.size() != 0));
    check("a_in_ready", 64'(a_if.in_ready), 64'(exp_q.size() != D1));
    check("a_count", 64'(a_if.count), 64'(exp_q.size()));
    if (exp_q.size() != 0) check("a_out_data", a_if.out_data, exp_q[0]);
  endtask

  // One clock for DUT A; the model applies the same transfer rules from pre-edge state.
  task automatic tick_a();
    logic acc, rd;
    logic [7:0] b;
    logic [63:0] w;
    acc = a_if.in_valid && (exp_q.size() != D1);
    rd  = a_if.out_ready && (exp_q.size() != 0);
    b   = a_if.in_data;
    @(posedge clk);
    #1;
    if (rd) void'(exp_q.pop_front());
    if (acc) begin
      part_q.push_back(b);
      if (part_q.size() == 8) begin
        w = 64'd0;
        for (int i = 0; i < 8; i++) w = w | (64'(part_q[i]) << (8 * i));
        exp_q.push_back(w);
        part_q.delete();
      end
    end
    last_acc = acc;
    check_a();
  endtask

  task automatic push_a(input logic [7:0] b, input logic rdy);
    a_if.in_valid  = 1'b1;
    a_if.in_data   = b;
    a_if.out_ready = rdy;
    tick_a();
    a_if.in_valid  = 1'b0;
    a_if.out_ready = 1'b0;
  endtask

  task automatic drain_a();
    a_if.in_valid  = 1'b0;
    a_if.out_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick_a();
    a_if.out_ready = 1'b0;
    check("a_drained", 64'(a_if.out_valid), 64'd0);
  endtask

  task automatic tick_b();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  pend;
    logic [31:0] bexp [4];
    int          sent;
    int          cyc;

    rst_n = 1'b0;
    a_if.in_valid = 1'b0; a_if.in_data = 8'd0;  a_if.out_ready = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_data = 16'd0; b_if.out_ready = 1'b0;
    last_acc = 1'b0;
    #12;
    check_a();
    rst_n = 1'b1;
    tick_a();

    // Single pack 0x01..0x08
    for (int i = 1; i <= 8; i++) push_a(8'(i), 1'b0);
    check("single_pack_data", a_if.out_data, 64'h0807060504030201);
    check("single_pack_count", 64'(a_if.count), 64'd1);
    drain_a();

    // Partial hold: 5 bytes invisible, 3 more complete the word
    for (int i = 0; i < 5; i++) push_a(8'($urandom), 1'b0);
    check("partial_count", 64'(a_if.count), 64'd0);
    for (int i = 0; i < 3; i++) push_a(8'($urandom), 1'b0);
    drain_a();

    // Reset mid-word discards the partial word
    for (int i = 0; i < 3; i++) push_a(8'($urandom), 1'b0);
    rst_n = 1'b0;
    #2;
    part_q.delete();
    exp_q.delete();
    check_a();
    rst_n = 1'b1;
    tick_a();
    for (int i = 0; i < 8; i++) push_a(8'(8'h11 + i), 1'b0);
    check("post_reset_data", a_if.out_data, 64'h1817161514131211);
    drain_a();

    // Fill to full, offer one extra byte, then one read reopens in_ready
    for (int i = 0; i < 256; i++) push_a(8'($urandom), 1'b0);
    check("full_in_ready", 64'(a_if.in_ready), 64'd0);
    check("full_count", 64'(a_if.count), 64'd32);
    push_a(8'hEE, 1'b0);
    a_if.out_ready = 1'b1;
    tick_a();
    a_if.out_ready = 1'b0;
    check("reopen_in_ready", 64'(a_if.in_ready), 64'd1);
    drain_a();

    // Simultaneous complete and read at count=4
    for (int i = 0; i < 39; i++) push_a(8'($urandom), 1'b0);
    push_a(8'($urandom), 1'b1);
    check("simul_count", 64'(a_if.count), 64'd4);
    drain_a();

    // Randomized streaming of 1000 bytes
    sent = 0;
    cyc  = 0;
    pend = 8'($urandom);
    while (sent < 1000 && cyc < 20000) begin
      a_if.in_valid  = 1'($urandom_range(0, 1));
      a_if.in_data   = pend;
      a_if.out_ready = 1'($urandom_range(0, 1));
      tick_a();
      if (last_acc) begin
        sent++;
        pend = 8'($urandom);
      end
      cyc++;
    end
    check("stream_sent", 64'(sent), 64'd1000);
    drain_a();

    // 16->32, depth 4 instance
    bexp[0] = 32'hBBBBAAAA;
    bexp[1] = 32'h10011000;
    bexp[2] = 32'h10031002;
    bexp[3] = 32'h10051004;
    check("b_reset_valid", 64'(b_if.out_valid), 64'd0);
    b_if.in_valid = 1'b1;
    b_if.in_data  = 16'hAAAA;
    tick_b();
    check("b_half_valid", 64'(b_if.out_valid), 64'd0);
    b_if.in_data  = 16'hBBBB;
    tick_b();
    b_if.in_valid = 1'b0;
    check("b_valid", 64'(b_if.out_valid), 64'd1);
    check("b_data", 64'(b_if.out_data), 64'h00000000BBBBAAAA);
    check("b_count1", 64'(b_if.count), 64'd1);
    for (int i = 0; i < 6; i++) begin
      b_if.in_valid = 1'b1;
      b_if.in_data  = 16'(16'h1000 + i);
      tick_b();
    end
    check("b_full_count", 64'(b_if.count), 64'd4);
    check("b_full_ready", 64'(b_if.in_ready), 64'd0);
    b_if.in_data = 16'hEEEE;
    tick_b();
    b_if.in_valid = 1'b0;
    check("b_full_hold", 64'(b_if.count), 64'd4);
    b_if.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("b_read_data", 64'(b_if.out_data), 64'(bexp[k]));
      tick_b();
    end
    b_if.out_ready = 1'b0;
    check("b_empty_valid", 64'(b_if.out_valid), 64'd0);
    check("b_empty_count", 64'(b_if.count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
